// File: rtl/mel_filterbank_engine.sv
// mel_filterbank_engine
//   Applies the mel coefficient ROM to one frame of power spectrum and emits
//   MEL_BINS filter energies, in order 0..MEL_BINS-1, over a valid/ready stream.
//   Sits between the FFT power-spectrum buffer and the log stage.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   start / busy / done           frame control (start accepted only in IDLE)
//   mel_idx, coeff_idx            ROM select (weight_in/start_bin/end_bin return combinationally)
//   weight_in, start_bin, end_bin ROM data
//   spec_addr, spec_rd, spec_data spectrum RAM port (data one cycle after spec_rd)
//   mel_valid, mel_ready,
//   mel_energy, mel_last          output stream
//   dbg_state                     current FSM state (IDLE=0 FETCH=1 MAC=2 DRAIN=3 OUT=4 DONE=5)
//
// Stream handshake: mel_energy/mel_last are presented with mel_valid and held
// unchanged until the cycle in which mel_valid && mel_ready (the transfer);
// mel_valid never drops without a transfer.
//
// Configuration macro MEL_SAT_EN: when defined, energies above 2^OUT_W-1 clamp
// to all ones; otherwise the low OUT_W bits are emitted.
module mel_filterbank_engine #(
  parameter int MEL_BINS   = 40,
  parameter int MAX_COEFFS = 16,
  parameter int COEFF_W    = 16,
  parameter int BIN_W      = 7,
  parameter int NUM_BINS   = 128,
  parameter int POW_W      = 32,
  parameter int OUT_W      = 32,
  parameter int ACC_W      = POW_W + COEFF_W + $clog2(MAX_COEFFS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(MEL_BINS)-1:0]   mel_idx,
  output logic [$clog2(MAX_COEFFS)-1:0] coeff_idx,
  input  logic [COEFF_W-1:0]            weight_in,
  input  logic [BIN_W-1:0]              start_bin,
  input  logic [BIN_W-1:0]              end_bin,
  output logic [BIN_W-1:0]              spec_addr,
  output logic                          spec_rd,
  input  logic [POW_W-1:0]              spec_data,
  output logic                          mel_valid,
  input  logic                          mel_ready,
  output logic [OUT_W-1:0]              mel_energy,
  output logic                          mel_last,
  output logic [2:0]                    dbg_state
);

  localparam int MW = $clog2(MEL_BINS);
  localparam int KW = $clog2(MAX_COEFFS);
  localparam int NW = KW + 1;
  localparam int AW = BIN_W + KW + 1;
  localparam int PW = POW_W + COEFF_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_MAC   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]         r_state;
  logic [MW-1:0]      r_m;
  logic [KW-1:0]      r_k;
  logic [NW-1:0]      r_n;
  logic [BIN_W-1:0]   r_start;
  logic [COEFF_W-1:0] r_w;
  logic               r_pv;    // r_w pairs with a real read arriving on spec_data
  logic [ACC_W-1:0]   r_acc;

  logic [AW-1:0]      w_bin;
  logic               w_in_range;
  logic [BIN_W:0]     w_span;
  logic [NW-1:0]      w_n;
  logic [PW-1:0]      w_prod;
  logic [ACC_W-1:0]   w_shift;
  logic [OUT_W-1:0]   w_energy;
  logic               w_last;

  // Bin address is computed wide so start+k past the top of the bin space
  // is recognised as out of range instead of wrapping to a low bin.
  assign w_bin      = AW'(r_start) + AW'(r_k);
  assign w_in_range = (w_bin < AW'(NUM_BINS));

  // Coefficient count for the filter being fetched: inclusive span, capped,
  // and zero for an inverted (empty) filter.
  assign w_span = {1'b0, end_bin} - {1'b0, start_bin} + (BIN_W+1)'(1);
  always_comb begin
    w_n = '0;
    if (end_bin < start_bin)
      w_n = '0;
    else if (w_span > (BIN_W+1)'(MAX_COEFFS))
      w_n = NW'(MAX_COEFFS);
    else
      w_n = w_span[NW-1:0];
  end

  // Out-of-range bins were never read, so their product is forced to zero.
  assign w_prod = r_pv ? (PW'(r_w) * PW'(spec_data)) : '0;

  assign w_shift = r_acc >> (COEFF_W - 1);
`ifdef MEL_SAT_EN
  assign w_energy = (|w_shift[ACC_W-1:OUT_W]) ? {OUT_W{1'b1}} : w_shift[OUT_W-1:0];
`else
  assign w_energy = w_shift[OUT_W-1:0];
`endif

  assign w_last = (r_m == MW'(MEL_BINS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_m     <= '0;
      r_k     <= '0;
      r_n     <= '0;
      r_start <= '0;
      r_w     <= '0;
      r_pv    <= 1'b0;
      r_acc   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_m     <= '0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_start <= start_bin;
          r_n     <= w_n;
          r_k     <= '0;
          r_acc   <= '0;
          r_pv    <= 1'b0;
          r_state <= (w_n == '0) ? S_DRAIN : S_MAC;
        end
        S_MAC: begin
          r_w   <= weight_in;
          r_pv  <= w_in_range;
          r_acc <= r_acc + ACC_W'(w_prod);
          if (NW'(r_k) == r_n - NW'(1))
            r_state <= S_DRAIN;
          else
            r_k <= r_k + KW'(1);
        end
        S_DRAIN: begin
          r_acc   <= r_acc + ACC_W'(w_prod);
          r_pv    <= 1'b0;
          r_state <= S_OUT;
        end
        S_OUT: begin
          if (mel_ready) begin
            if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_m     <= r_m + MW'(1);
              r_state <= S_FETCH;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dbg_state  = r_state;
  assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done       = (r_state == S_DONE);
  assign mel_idx    = r_m;
  assign coeff_idx  = (r_state == S_MAC) ? r_k : '0;
  assign spec_rd    = (r_state == S_MAC) && w_in_range;
  assign spec_addr  = spec_rd ? w_bin[BIN_W-1:0] : '0;
  assign mel_valid  = (r_state == S_OUT);
  assign mel_energy = mel_valid ? w_energy : '0;
  assign mel_last   = mel_valid && w_last;

endmodule

// File: tb/tb_mel_filterbank_engine.sv
module tb_mel_filterbank_engine;

  localparam int MB = 40;
  localparam int MC = 16;
  localparam int BW = 8;   // wide enough to express end_bin=129 against NUM_BINS=128
  localparam int NB = 128;

`ifdef MEL_SAT_EN
  localparam logic [31:0] E5 = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] E5 = 32'hFFFF_FFF0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic        busy, done;
  logic [5:0]  mel_idx;
  logic [3:0]  coeff_idx;
  logic [15:0] weight_in;
  logic [BW-1:0] start_bin, end_bin, spec_addr;
  logic        spec_rd;
  logic [31:0] spec_data = '0;
  logic        mel_valid;
  logic        mel_ready = 1'b1;
  logic [31:0] mel_energy;
  logic        mel_last;
  logic [2:0]  dbg_state;

  mel_filterbank_engine #(
    .MEL_BINS(MB), .MAX_COEFFS(MC), .COEFF_W(16), .BIN_W(BW),
    .NUM_BINS(NB), .POW_W(32), .OUT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mel_idx(mel_idx), .coeff_idx(coeff_idx), .weight_in(weight_in),
    .start_bin(start_bin), .end_bin(end_bin), .spec_addr(spec_addr),
    .spec_rd(spec_rd), .spec_data(spec_data), .mel_valid(mel_valid),
    .mel_ready(mel_ready), .mel_energy(mel_energy), .mel_last(mel_last),
    .dbg_state(dbg_state)
  );

  // ROM and spectrum RAM models
  logic [15:0]   w_mem [MB][MC];
  logic [BW-1:0] rom_s [MB];
  logic [BW-1:0] rom_e [MB];
  logic [31:0]   spec_mem [256];

  assign weight_in = (mel_idx < 6'(MB)) ? w_mem[mel_idx][coeff_idx] : 16'h0;
  assign start_bin = (mel_idx < 6'(MB)) ? rom_s[mel_idx] : '0;
  assign end_bin   = (mel_idx < 6'(MB)) ? rom_e[mel_idx] : '0;

  always @(posedge clk) if (spec_rd) spec_data <= spec_mem[spec_addr];

  // scoreboard
  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  int rd_cnt [MB];
  int lat [MB];
  int t_f [MB];
  int n_hs, n_done, bad_addr, rd_in_out, hold_bad, stall_cnt, timed_out, post_idle_bad;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_base(input logic [31:0] p);
    for (int i = 0; i < 256; i++) spec_mem[i] = p;
    for (int m = 0; m < MB; m++) begin
      rom_s[m] = BW'(2 * m);
      rom_e[m] = BW'(2 * m + 3);
      for (int k = 0; k < MC; k++) w_mem[m][k] = 16'h8000;
    end
  endtask

  task automatic fill_exp(input logic [31:0] v);
    exp_q.delete();
    for (int m = 0; m < MB; m++) exp_q.push_back(v);
  endtask

  // Runs one frame: pulses start, optionally stalls filter stall_m for
  // stall_len cycles, optionally pokes start mid-frame and in the DONE cycle.
  task automatic run_frame(input string tag, input int stall_m, input int stall_len, input bit poke);
    int cur, cyc, fin;
    logic [31:0] held, e;
    cur = 0; cyc = 0; fin = 0; held = '0;
    n_hs = 0; n_done = 0; bad_addr = 0; rd_in_out = 0; hold_bad = 0;
    stall_cnt = 0; timed_out = 0; post_idle_bad = 0;
    for (int m = 0; m < MB; m++) begin rd_cnt[m] = 0; lat[m] = -1; t_f[m] = 0; end
    start = 1'b1;
    @(negedge clk);
    while (fin == 0 && cyc < 3000) begin
      start = 1'b0;
      if (poke && cyc == 10) start = 1'b1;
      if (dbg_state == 3'd1) t_f[mel_idx] = cyc;
      if (spec_rd) begin
        rd_cnt[mel_idx]++;
        if (spec_addr >= BW'(NB)) bad_addr++;
      end
      if (mel_valid && spec_rd) rd_in_out++;
      if (mel_valid && lat[mel_idx] < 0) lat[mel_idx] = cyc - t_f[mel_idx];
      mel_ready = !(mel_valid && int'(mel_idx) == stall_m && stall_cnt < stall_len);
      if (mel_valid && !mel_ready) begin
        if (stall_cnt == 0) held = mel_energy;
        else if (mel_energy !== held) hold_bad++;
        stall_cnt++;
      end
      if (mel_valid && mel_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check({tag, " idx"}, 64'(mel_idx), 64'(cur));
        check({tag, " energy"}, 64'(mel_energy), 64'(e));
        check({tag, " last"}, 64'(mel_last), 64'(cur == MB - 1));
        if (stall_m == cur && stall_len > 0)
          check({tag, " held energy"}, 64'(mel_energy), 64'(held));
        cur++;
        n_hs++;
      end
      if (done) begin
        n_done++;
        check({tag, " busy at done"}, 64'(busy), 64'd0);
        if (poke) start = 1'b1;
        fin = 1;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    mel_ready = 1'b1;
    if (fin == 0) timed_out = 1;
    // one cycle after DONE: IDLE, start given in DONE not taken
    if (dbg_state != 3'd0 || busy || done) post_idle_bad = 1;
    check({tag, " timeout"}, 64'(timed_out), 64'd0);
    check({tag, " handshakes"}, 64'(n_hs), 64'(MB));
    check({tag, " done pulses"}, 64'(n_done), 64'd1);
    check({tag, " idle after done"}, 64'(post_idle_bad), 64'd0);
    check({tag, " reads during OUT"}, 64'(rd_in_out), 64'd0);
    check({tag, " read addr range"}, 64'(bad_addr), 64'd0);
  endtask

  initial begin
    int w;
    // reset state
    cfg_base(32'd1000);
    repeat (3) @(negedge clk);
    check("reset outputs",
          64'({busy, done, mel_idx, coeff_idx, spec_addr, spec_rd, mel_valid, mel_energy, mel_last}),
          64'd0);
    check("reset state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: uniform frame, n=4 per filter, start pokes while busy and in DONE
    cfg_base(32'd1000);
    fill_exp(32'd4000);
    run_frame("t1", -1, 0, 1'b1);
    check("t1 latency f0", 64'(lat[0]), 64'd6);
    check("t1 reads f5", 64'(rd_cnt[5]), 64'd4);
    check("t1 reads f39", 64'(rd_cnt[39]), 64'd4);

    // Test 2: stall filter 7 for 5 cycles
    fill_exp(32'd4000);
    run_frame("t2", 7, 5, 1'b0);
    check("t2 stall cycles", 64'(stall_cnt), 64'd5);
    check("t2 hold stable", 64'(hold_bad), 64'd0);
    check("t2 reads f7", 64'(rd_cnt[7]), 64'd4);

    // Test 3: filter 3 inverted range -> energy 0, FETCH->OUT = 2
    cfg_base(32'd1000);
    rom_s[3] = BW'(10);
    rom_e[3] = BW'(5);
    fill_exp(32'd4000);
    exp_q[3] = 32'd0;
    run_frame("t3", -1, 0, 1'b0);
    check("t3 latency f3", 64'(lat[3]), 64'd2);
    check("t3 reads f3", 64'(rd_cnt[3]), 64'd0);
    check("t3 latency f4", 64'(lat[4]), 64'd6);

    // Test 4: filter 0 straddles NUM_BINS: only 126,127 read; (3000+5000)*0.5*2 = 8000
    cfg_base(32'd1000);
    rom_s[0] = BW'(126);
    rom_e[0] = BW'(129);
    spec_mem[126] = 32'd3000;
    spec_mem[127] = 32'd5000;
    spec_mem[128] = 32'd7777;
    spec_mem[129] = 32'd7777;
    fill_exp(32'd4000);
    exp_q[0] = 32'd8000;
    run_frame("t4", -1, 0, 1'b0);
    check("t4 reads f0", 64'(rd_cnt[0]), 64'd2);
    check("t4 latency f0", 64'(lat[0]), 64'd6);

    // Test 5: full-scale power, 16 coefficients; filter 1 span 26 is capped to 16
    cfg_base(32'hFFFF_FFFF);
    for (int m = 0; m < MB; m++) begin
      rom_s[m] = BW'(m);
      rom_e[m] = BW'(m + 15);
    end
    rom_e[1] = BW'(26);
    fill_exp(E5);
    run_frame("t5", -1, 0, 1'b0);
    check("t5 latency f0", 64'(lat[0]), 64'd18);
    check("t5 latency f1 capped", 64'(lat[1]), 64'd18);
    check("t5 reads f1 capped", 64'(rd_cnt[1]), 64'd16);

    // Test 6: reset in MAC at filter 20, then a clean restart
    cfg_base(32'd1000);
    mel_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!(mel_idx == 6'd20 && dbg_state == 3'd2) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("t6 reached f20 MAC", 64'(w < 2000), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6 outputs after reset",
          64'({busy, done, mel_idx, coeff_idx, spec_addr, spec_rd, mel_valid, mel_energy, mel_last}),
          64'd0);
    check("t6 state after reset", 64'(dbg_state), 64'd0);
    n_done = 0;
    for (int i = 0; i < 5; i++) begin
      if (done || busy) n_done++;
      @(negedge clk);
    end
    check("t6 quiet after reset", 64'(n_done), 64'd0);
    fill_exp(32'd4000);
    run_frame("t6", -1, 0, 1'b0);
    check("t6 latency f0", 64'(lat[0]), 64'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
